// File: rtl/exe_wb_pipe_stage_pkg.sv
// Shared widths, state encoding and write-enable qualification for the EXE->WB stage.
package exe_wb_pipe_stage_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ASIZE_DEF = 5;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } pipe_state_t;

  // With zero_reg set, a write aimed at register 0 is squashed at capture time.
  function automatic logic qualify_wen(input logic wen, input logic addr_nonzero,
                                       input logic zero_reg);
    return wen & (addr_nonzero | ~zero_reg);
  endfunction

endpackage

// File: rtl/exe_wb_pipe_stage_pipe_slot.sv
// One pipeline entry {data, addr, wen, valid}; clear drops valid but keeps the payload.
module pipe_slot
  import exe_wb_pipe_stage_pkg::*;
#(
  parameter int DW = DSIZE_DEF,
  parameter int AW = ASIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d_data,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wen,
  output logic [DW-1:0] q_data,
  output logic [AW-1:0] q_addr,
  output logic          q_wen,
  output logic          q_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_data  <= '0;
      q_addr  <= '0;
      q_wen   <= 1'b0;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_addr  <= d_addr;
      q_wen   <= d_wen;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/exe_wb_pipe_stage.sv
// EXE->WB pipeline register with one-entry skid buffer, flush and stall counter.
// Optional combinational forwarding compare is built when EXE_WB_FWD_EN is defined.
//
// state   | meaning
// S_EMPTY | M and S empty, in_ready=1
// S_ONE   | M full, S empty, in_ready=1
// S_TWO   | M and S full, in_ready=0
module exe_wb_pipe_stage
  import exe_wb_pipe_stage_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int ASIZE    = ASIZE_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] alu_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
`ifdef EXE_WB_FWD_EN
  input  logic [ASIZE-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [DSIZE-1:0] fwd_data,
`endif
  output logic [15:0]      stall_cnt
);

  pipe_state_t state, state_nxt;

  logic             m_load, m_clear, s_load, s_clear;
  logic [DSIZE-1:0] m_data, s_data, m_d_data;
  logic [ASIZE-1:0] m_addr, s_addr, m_d_addr;
  logic             m_wen, s_wen, m_d_wen, m_valid, s_valid;
  logic             wen_qual, accept, drain;

  assign in_ready = (state != S_TWO);
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;
  assign wen_qual = qualify_wen(wen_in, |waddr_in, ZERO_REG != 0);

  // S holds the older pending entry whenever it is valid, so M refills from it first.
  assign m_d_data = s_valid ? s_data : alu_in;
  assign m_d_addr = s_valid ? s_addr : waddr_in;
  assign m_d_wen  = s_valid ? s_wen  : wen_qual;

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
      m_clear   = 1'b1;
      s_clear   = 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            m_load    = 1'b1;
            state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load    = 1'b1;
            state_nxt = S_TWO;
          end else if (drain) begin
            m_clear   = 1'b1;
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            m_load    = 1'b1;
            s_clear   = 1'b1;
            state_nxt = S_ONE;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
          m_clear   = 1'b1;
          s_clear   = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.DW(DSIZE), .AW(ASIZE)) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clear   (m_clear),
    .d_data  (m_d_data),
    .d_addr  (m_d_addr),
    .d_wen   (m_d_wen),
    .q_data  (m_data),
    .q_addr  (m_addr),
    .q_wen   (m_wen),
    .q_valid (m_valid)
  );

  pipe_slot #(.DW(DSIZE), .AW(ASIZE)) u_slot_s (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .clear   (s_clear),
    .d_data  (alu_in),
    .d_addr  (waddr_in),
    .d_wen   (wen_qual),
    .q_data  (s_data),
    .q_addr  (s_addr),
    .q_wen   (s_wen),
    .q_valid (s_valid)
  );

  assign out_valid = m_valid;
  assign alu_out   = m_data;
  assign waddr_out = m_addr;
  assign wen_out   = m_valid & m_wen;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (m_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

`ifdef EXE_WB_FWD_EN
  logic s_match, m_match;

  assign s_match = s_valid & s_wen & (s_addr == fwd_raddr);
  assign m_match = m_valid & m_wen & (m_addr == fwd_raddr);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (s_match) begin
      fwd_hit  = 1'b1;
      fwd_data = s_data;
    end else if (m_match) begin
      fwd_hit  = 1'b1;
      fwd_data = m_data;
    end
  end
`endif

endmodule

// File: tb/tb_exe_wb_pipe_stage.sv
// Randomised and directed bench for exe_wb_pipe_stage against a queue-based reference model.
module tb_exe_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, wen_in, out_valid, out_ready, wen_out;
  logic [15:0] alu_in, alu_out, stall_cnt;
  logic [4:0]  waddr_in, waddr_out;
`ifdef EXE_WB_FWD_EN
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  exe_wb_pipe_stage #(.DSIZE(16), .ASIZE(5), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_in    (alu_in),
    .waddr_in  (waddr_in),
    .wen_in    (wen_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .waddr_out (waddr_out),
    .wen_out   (wen_out),
`ifdef EXE_WB_FWD_EN
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  addr;
    logic        wen;
  } entry_t;

  entry_t q[$];
  int     mdl_stall = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("wen_out", {31'd0, wen_out}, (q.size() > 0) ? {31'd0, q[0].wen} : 32'd0);
    chk("stall_cnt", {16'd0, stall_cnt}, mdl_stall);
    if (q.size() > 0) begin
      chk("alu_out", {16'd0, alu_out}, {16'd0, q[0].data});
      chk("waddr_out", {27'd0, waddr_out}, {27'd0, q[0].addr});
    end
`ifdef EXE_WB_FWD_EN
    begin
      logic        hit = 1'b0;
      logic [15:0] fd = '0;
      for (int i = 0; i < q.size(); i++)
        if (q[i].wen && q[i].addr == fwd_raddr) begin
          hit = 1'b1;
          fd  = q[i].data;
        end
      chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
      chk("fwd_data", {16'd0, fwd_data}, {16'd0, fd});
    end
`endif
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare at negedge.
  task automatic step(input logic r, input logic f, input logic iv, input logic [15:0] d,
                      input logic [4:0] a, input logic w, input logic ordy,
                      input logic [4:0] fa, input logic do_cmp);
    entry_t e;
    logic   acc;
    rst = r; flush = f; in_valid = iv; alu_in = d; waddr_in = a; wen_in = w; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      mdl_stall = 0;
    end else begin
      if (q.size() > 0 && !ordy && mdl_stall < 65535) mdl_stall++;
      if (f) q.delete();
      else begin
        acc = iv && (q.size() < 2);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
          e.data = d;
          e.addr = a;
          e.wen  = w && (a != 5'd0);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
`ifdef EXE_WB_FWD_EN
    fwd_raddr = fa;
`endif
    #1;
    if (do_cmp) compare_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_in = '0; waddr_in = '0;
    wen_in = 1'b0; out_ready = 1'b0;
`ifdef EXE_WB_FWD_EN
    fwd_raddr = '0;
`endif
    @(negedge clk);

    // reset then streaming
    step(1, 0, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);
    step(1, 0, 1, 16'h5555, 5'd7, 1, 1, 5'd0, 1);
    chk("rst_alu", {16'd0, alu_out}, 32'd0);
    chk("rst_waddr", {27'd0, waddr_out}, 32'd0);
    step(0, 0, 1, 16'h1234, 5'd3, 1, 1, 5'd3, 1);
    chk("strm_data", {16'd0, alu_out}, 32'h1234);
    chk("strm_wen", {31'd0, wen_out}, 32'd1);
    step(0, 0, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);

    // back-pressure: A, B, rejected C, then drain in order
    step(0, 0, 1, 16'h0001, 5'd1, 1, 0, 5'd1, 1);
    step(0, 0, 1, 16'h0002, 5'd2, 1, 0, 5'd2, 1);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    step(0, 0, 1, 16'h0003, 5'd3, 1, 0, 5'd3, 1);
    chk("bp_stall", {16'd0, stall_cnt}, 32'd2);
    step(0, 0, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);
    chk("bp_b", {16'd0, alu_out}, 32'h0002);
    step(0, 0, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush while full with an incoming beat
    step(0, 0, 1, 16'h00A0, 5'd4, 1, 0, 5'd4, 1);
    step(0, 0, 1, 16'h00B0, 5'd5, 1, 0, 5'd5, 1);
    step(0, 1, 1, 16'hDEAD, 5'd6, 1, 0, 5'd6, 1);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 0, 16'h0, 5'd0, 0, 1, 5'd6, 1);

    // zero register squash
    step(0, 0, 1, 16'h7777, 5'd0, 1, 1, 5'd0, 1);
    chk("zr_valid", {31'd0, out_valid}, 32'd1);
    chk("zr_wen", {31'd0, wen_out}, 32'd0);
    step(0, 0, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);

`ifdef EXE_WB_FWD_EN
    step(0, 0, 1, 16'hAAAA, 5'd4, 1, 0, 5'd4, 1);
    step(0, 0, 1, 16'hBBBB, 5'd4, 1, 0, 5'd4, 1);
    chk("fwd_s_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_s_data", {16'd0, fwd_data}, 32'hBBBB);
    fwd_raddr = 5'd5;
    #1;
    chk("fwd_miss", {31'd0, fwd_hit}, 32'd0);
    step(0, 1, 0, 16'h0, 5'd0, 0, 1, 5'd0, 1);
`endif

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1), 16'($urandom), 5'($urandom_range(0, 5)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 5)), 1);
    end

    // counter saturation
    step(1, 0, 0, 16'h0, 5'd0, 0, 0, 5'd0, 1);
    step(0, 0, 1, 16'h4242, 5'd9, 1, 0, 5'd0, 1);
    for (int i = 0; i < 70000; i++)
      step(0, 0, 0, 16'h0, 5'd0, 0, 0, 5'd0, (i % 1000) == 0);
    chk("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    step(0, 1, 0, 16'h0, 5'd0, 0, 0, 5'd0, 1);
    chk("sat_flush", {16'd0, stall_cnt}, 32'hFFFF);
    step(1, 0, 0, 16'h0, 5'd0, 0, 0, 5'd0, 1);
    chk("sat_rst", {16'd0, stall_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_wb_pipe_stage.md
Name: exe_wb_pipe_stage

Overview:
- Parametrised EXE->WB pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Supports flush and carries a write-enable qualifier.
- Sits between the ALU (EXE) and the register-file write port (WB).
- Lets WB back-pressure EXE without a combinational ready path and without dropping data.

Parameters:
- DSIZE, `DSIZE from define.v (16): ALU result width.
- ASIZE, `ASIZE from define.v (5): register-file write address width.
- ZERO_REG, 1: when 1, writes to address 0 are squashed (wen forced to 0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all held entries this cycle.
- in_valid  input  1  EXE presents a result.
- in_ready  output  1  stage can accept; registered, not combinational from out_ready.
- alu_in  input  DSIZE  ALU result.
- waddr_in  input  ASIZE  destination register.
- wen_in  input  1  result is to be written.
- out_valid  output  1  WB entry valid.
- out_ready  input  1  WB consumes the entry.
- alu_out  output  DSIZE  result to WB.
- waddr_out  output  ASIZE  destination to WB.
- wen_out  output  1  qualified write enable (0 when out_valid=0).
- stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0; saturates at 0xFFFF.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values (all outputs):
  - out_valid=0, alu_out=0, waddr_out=0, wen_out=0, stall_cnt=0.
  - skid entry empty; in_ready=1 in the first cycle after reset.
- Storage: main register M (drives outputs) and skid register S, each holding {alu, waddr, wen, valid}.
- Handshakes:
  - Accept: in_valid & in_ready.
  - Drain: out_valid & out_ready.
  - Latency: 1 cycle from accept to out_valid when M is empty or draining.
- States (S_EMPTY is the reset state):
  - S_EMPTY: M and S empty; in_ready=1.
    - On accept -> S_ONE.
  - S_ONE: M full, S empty; in_ready=1.
    - Accept with drain: M reloads -> S_ONE.
    - Accept without drain: data goes to S -> S_TWO.
    - Drain without accept -> S_EMPTY.
  - S_TWO: M and S full; in_ready=0.
    - On drain: S moves to M -> S_ONE.
    - in_valid is ignored in S_TWO; no entry is lost or duplicated.
- Flush:
  - Takes priority over accept and drain.
  - Next state S_EMPTY; valids cleared; data registers are don't-care but hold their old values.
  - An accept in the same cycle as flush is discarded.
- rst takes priority over flush.
- rst mid-transfer clears both entries; nothing is retired.
- Write-enable qualification:
  - wen_out = M.valid & M.wen.
  - With ZERO_REG=1, M.wen is captured as wen_in & (waddr_in != 0).
- Ordering: strict FIFO order; S is never bypassed by newer data.
- stall_cnt:
  - Increments every cycle with out_valid & ~out_ready.
  - Holds at 0xFFFF when saturated.
  - Unaffected by flush; cleared only by rst.

Optional Feature:
- Macro: EXE_WB_FWD_EN.
- When defined, the block adds ports:
  - fwd_raddr input ASIZE.
  - fwd_hit output 1.
  - fwd_data output DSIZE.
- Forwarding is combinational: fwd_hit=1 when a valid, wen-qualified entry matches fwd_raddr.
  - S (the younger entry) has priority over M.
  - fwd_data is that entry's alu value, else 0.
- When not defined, these ports and all compare logic are absent.

Decomposition:
- DSIZE/ASIZE and the 2-bit state encodings (S_EMPTY=0, S_ONE=1, S_TWO=2) go in define.v.
- One natural sub-module: pipe_slot, a parametrised {data, addr, wen, valid} register with load, clear and synchronous reset, instantiated twice (M, S).

Test Plan:
- Reset and streaming:
  - Stimulus: rst=1 for 2 cycles, then in_valid=1, alu_in=0x1234, waddr_in=3, wen_in=1, out_ready=1.
  - Response: outputs all 0 during reset; next cycle out_valid=1, alu_out=0x1234, waddr_out=3, wen_out=1.
- Back-pressure:
  - Stimulus: out_ready=0; push A=0x0001, then B=0x0002.
  - Response: in_ready=0 after B; stall_cnt counts; on out_ready=1, A then B appear on consecutive cycles; no third entry accepted.
- Flush:
  - Stimulus: in S_TWO, assert flush with in_valid=1.
  - Response: next cycle out_valid=0, in_ready=1; the flushed and incoming data never appear.
- Zero register:
  - Stimulus: ZERO_REG=1, waddr_in=0, wen_in=1.
  - Response: out_valid=1, wen_out=0.
- Forwarding (EXE_WB_FWD_EN defined):
  - Stimulus: M={addr 4, 0xAAAA}, S={addr 4, 0xBBBB}, fwd_raddr=4.
  - Response: fwd_hit=1, fwd_data=0xBBBB; fwd_raddr=5 -> fwd_hit=0.
- Counter saturation:
  - Stimulus: hold a stall for 70000 cycles.
  - Response: stall_cnt=0xFFFF; a later rst clears it to 0.
